// File: rtl/karatsuba_pkg.sv
// Shared types and elaboration helpers for the GF(2)[x] multiplier library.
package karatsuba_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_COMBINE = 2'd2
    } kara_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Smallest r with 2**r >= v; returns at least 1 so counters never collapse to 0 bits.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clmul_digit_serial.sv
// Digit-serial carry-less multiplier: consumes DIGIT bits of y per cycle, LSB first.
module clmul_digit_serial
#(
    parameter int N     = 117,
    parameter int DIGIT = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    output logic [2*N-2:0]   p
);
    localparam int PW = 2*N - 1;

    logic [PW-1:0] r_x;
    logic [PW-1:0] r_acc;
    logic [N-1:0]  r_y;
    logic [PW-1:0] w_part;

    // Once y has shifted out to zero the accumulator stops changing, so no enable is needed.
    always_comb begin
        w_part = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (r_y[j]) w_part = w_part ^ (r_x << j);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_acc <= '0;
        end else if (load) begin
            r_x   <= {{(PW-N){1'b0}}, x};
            r_y   <= y;
            r_acc <= '0;
        end else begin
            r_acc <= r_acc ^ w_part;
            r_x   <= r_x << DIGIT;
            r_y   <= r_y >> DIGIT;
        end
    end

    assign p = r_acc;

endmodule

// File: rtl/seq_karatsuba_gf2.sv
// Sequential one-level Karatsuba GF(2)[x] multiplier built on three digit-serial sub-products.
module seq_karatsuba_gf2
    import karatsuba_pkg::*;
#(
    parameter int WIDTH = 233,
    parameter int DIGIT = 1
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   c
);
    localparam int L  = WIDTH / 2;
    localparam int H  = WIDTH - L;
    localparam int K  = ceil_div(H, DIGIT);
    localparam int CW = clog2(K + 1);
    localparam int PW = 2*H - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    kara_state_e          r_state;
    kara_state_e          w_state_next;
    logic [CW-1:0]        r_cnt;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_c;
    logic                 w_load;

    logic [H-1:0]         w_ah, w_al, w_bh, w_bl, w_am, w_bm;
    logic [PW-1:0]        w_phh, w_pll, w_pm;
    logic [2*WIDTH-1:0]   w_hh, w_ll, w_mid, w_comb;

    // Low halves are zero-extended to H bits so all three sub-products share one size.
    always_comb begin
        w_ah = a[WIDTH-1:L];
        w_bh = b[WIDTH-1:L];
        w_al = '0;
        w_bl = '0;
        w_al[L-1:0] = a[L-1:0];
        w_bl[L-1:0] = b[L-1:0];
        w_am = w_ah ^ w_al;
        w_bm = w_bh ^ w_bl;
    end

    assign w_load = (r_state == ST_IDLE) && start;

    clmul_digit_serial #(.N(H), .DIGIT(DIGIT)) u_hh (
        .clk(clk), .rst(rst), .load(w_load), .x(w_ah), .y(w_bh), .p(w_phh)
    );
    clmul_digit_serial #(.N(H), .DIGIT(DIGIT)) u_ll (
        .clk(clk), .rst(rst), .load(w_load), .x(w_al), .y(w_bl), .p(w_pll)
    );
    clmul_digit_serial #(.N(H), .DIGIT(DIGIT)) u_mm (
        .clk(clk), .rst(rst), .load(w_load), .x(w_am), .y(w_bm), .p(w_pm)
    );

    // In GF(2) the middle term's subtractions become XORs.
    always_comb begin
        w_hh  = '0;
        w_ll  = '0;
        w_mid = '0;
        w_hh[PW-1:0]  = w_phh;
        w_ll[PW-1:0]  = w_pll;
        w_mid[PW-1:0] = w_pm ^ w_phh ^ w_pll;
        w_comb = (w_hh << (2*L)) ^ (w_mid << L) ^ w_ll;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = ST_RUN;
            ST_RUN:     if (r_cnt == CNT_LAST) w_state_next = ST_COMBINE;
            ST_COMBINE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_c     <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_COMBINE);
            if (r_state == ST_COMBINE) r_c <= w_comb;
            if ((r_state == ST_RUN) && (r_cnt != CNT_LAST)) r_cnt <= r_cnt + 1'b1;
            else                                              r_cnt <= '0;
        end
    end

    assign busy = (r_state == ST_RUN) || (r_state == ST_COMBINE);
    assign done = r_done;
    assign c    = r_c;

endmodule

// File: tb/tb_seq_karatsuba_gf2.sv
// Directed and back-to-back checks of seq_karatsuba_gf2 across several WIDTH/DIGIT builds.
module tb_seq_karatsuba_gf2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT1: WIDTH=233 DIGIT=1 (K=117)
    logic st1 = 1'b0; logic [232:0] a1 = '0, b1 = '0; logic bz1, dn1; logic [465:0] c1;
    // DUT2: WIDTH=8 DIGIT=3 (K=2)
    logic st2 = 1'b0; logic [7:0] a2 = '0, b2 = '0; logic bz2, dn2; logic [15:0] c2;
    // DUT3: WIDTH=9 DIGIT=2 (K=3)
    logic st3 = 1'b0; logic [8:0] a3 = '0, b3 = '0; logic bz3, dn3; logic [17:0] c3;
    // DUT4: WIDTH=8 DIGIT=4 (K=1)
    logic st4 = 1'b0; logic [7:0] a4 = '0, b4 = '0; logic bz4, dn4; logic [15:0] c4;

    int n_cmp = 0;
    int n_bad = 0;

    seq_karatsuba_gf2 #(.WIDTH(233), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .busy(bz1), .done(dn1), .c(c1));
    seq_karatsuba_gf2 #(.WIDTH(8), .DIGIT(3)) u2 (
        .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .busy(bz2), .done(dn2), .c(c2));
    seq_karatsuba_gf2 #(.WIDTH(9), .DIGIT(2)) u3 (
        .clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3), .busy(bz3), .done(dn3), .c(c3));
    seq_karatsuba_gf2 #(.WIDTH(8), .DIGIT(4)) u4 (
        .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .busy(bz4), .done(dn4), .c(c4));

    function automatic logic [465:0] clmul(input logic [232:0] x, input logic [232:0] y);
        logic [465:0] r;
        r = '0;
        for (int i = 0; i < 233; i++) if (y[i]) r = r ^ ({233'b0, x} << i);
        return r;
    endfunction

    function automatic logic [232:0] rnd233();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[232:0];
    endfunction

    // Waits (bounded) for DUT1 done; n = edges after the accepting edge, -1 on timeout.
    task automatic wait1(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (dn1) begin n = i; return; end
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1; st1 = 1'b1; a1 = 233'd7; b1 = 233'd3;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bz1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b expected 0", bz1); end
        n_cmp++; if (dn1 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b expected 0", dn1); end
        n_cmp++; if (c1 !== '0)    begin n_bad++; $display("FAIL reset_c got %0h expected 0", c1); end
        n_cmp++; if ({bz2, bz3, bz4, dn2, dn3, dn4} !== 6'b0)
            begin n_bad++; $display("FAIL reset_small got %b expected 000000", {bz2, bz3, bz4, dn2, dn3, dn4}); end
        n_cmp++; if ({c2, c3, c4} !== '0)
            begin n_bad++; $display("FAIL reset_small_c got %0h expected 0", {c2, c3, c4}); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bz1 !== 1'b1) begin n_bad++; $display("FAIL first_accept_busy got %b expected 1", bz1); end
        @(negedge clk); st1 = 1'b0;
        wait1(n);
        n_cmp++; if (n !== 118) begin n_bad++; $display("FAIL first_accept_latency got %0d expected 118", n); end
        n_cmp++; if (c1 !== 466'd9) begin n_bad++; $display("FAIL first_accept_c got %0h expected 9", c1); end
    endtask

    task automatic test_latency;
        int n, nb;
        @(negedge clk); a1 = 233'd1; b1 = 233'd1; st1 = 1'b1;
        @(posedge clk); #1;
        nb = bz1 ? 1 : 0;
        @(negedge clk); st1 = 1'b0; a1 = '1; b1 = '1;
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (dn1) begin n = i; break; end
            if (bz1) nb++;
        end
        n_cmp++; if (n !== 118)   begin n_bad++; $display("FAIL latency_233 got %0d expected 118", n); end
        n_cmp++; if (nb !== 118)  begin n_bad++; $display("FAIL busy_cycles_233 got %0d expected 118", nb); end
        n_cmp++; if (bz1 !== 1'b0) begin n_bad++; $display("FAIL busy_at_done got %b expected 0", bz1); end
        n_cmp++; if (c1 !== 466'd1) begin n_bad++; $display("FAIL one_times_one got %0h expected 1", c1); end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (dn1 !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle got %b expected 0", dn1); end
        n_cmp++; if (c1 !== 466'd1) begin n_bad++; $display("FAIL c_hold got %0h expected 1", c1); end
    endtask

    task automatic test_squares;
        int n;
        logic [465:0] exp_c;
        @(negedge clk); a1 = 233'd1 << 232; b1 = 233'd1 << 232; st1 = 1'b1;
        @(posedge clk);
        @(negedge clk); st1 = 1'b0; a1 = '0; b1 = '0;
        wait1(n);
        exp_c = 466'd1 << 464;
        n_cmp++; if (n !== 118)    begin n_bad++; $display("FAIL top_square_latency got %0d expected 118", n); end
        n_cmp++; if (c1 !== exp_c) begin n_bad++; $display("FAIL top_square got %0h expected %0h", c1, exp_c); end
        @(negedge clk); a1 = (233'd1 << 116) | 233'd1; b1 = (233'd1 << 116) | 233'd1; st1 = 1'b1;
        @(posedge clk);
        @(negedge clk); st1 = 1'b0;
        wait1(n);
        exp_c = (466'd1 << 232) | 466'd1;
        n_cmp++; if (c1 !== exp_c) begin n_bad++; $display("FAIL cross_cancel got %0h expected %0h", c1, exp_c); end
    endtask

    task automatic test_digit3;
        int n;
        @(negedge clk); a2 = 8'hFF; b2 = 8'hFF; st2 = 1'b1;
        @(posedge clk);
        @(negedge clk); st2 = 1'b0; a2 = 8'h00; b2 = 8'h12;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (dn2) begin n = i; break; end
        end
        n_cmp++; if (n !== 3)          begin n_bad++; $display("FAIL w8d3_latency got %0d expected 3", n); end
        n_cmp++; if (c2 !== 16'h5555)  begin n_bad++; $display("FAIL w8d3_ff_square got %0h expected 5555", c2); end
        n_cmp++; if (bz2 !== 1'b0)     begin n_bad++; $display("FAIL w8d3_busy_at_done got %b expected 0", bz2); end
    endtask

    task automatic test_abort;
        int n;
        logic seen;
        seen = 1'b0;
        @(negedge clk); a1 = rnd233(); b1 = rnd233(); st1 = 1'b1;
        @(posedge clk);
        @(negedge clk); st1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (dn1) seen = 1'b1;
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({bz1, dn1} !== 2'b00) begin n_bad++; $display("FAIL abort_state got %b expected 00", {bz1, dn1}); end
        n_cmp++; if (c1 !== '0) begin n_bad++; $display("FAIL abort_c_cleared got %0h expected 0", c1); end
        @(negedge clk); rst = 1'b0; a1 = 233'd3; b1 = 233'd5; st1 = 1'b1;
        @(posedge clk);
        @(negedge clk); st1 = 1'b0;
        wait1(n);
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got %b expected 0", seen); end
        n_cmp++; if (n !== 118)     begin n_bad++; $display("FAIL after_abort_latency got %0d expected 118", n); end
        n_cmp++; if (c1 !== 466'hF) begin n_bad++; $display("FAIL after_abort_c got %0h expected f", c1); end
    endtask

    task automatic test_back_to_back;
        int p1, p2, p3, p4;
        logic [232:0] la1, lb1;
        logic [7:0]   la2, lb2, la4, lb4;
        logic [8:0]   la3, lb3;
        logic [465:0] e;
        logic         ex;
        p1 = 119; p2 = 4; p3 = 5; p4 = 3;
        la1 = '0; lb1 = '0; la2 = '0; lb2 = '0; la3 = '0; lb3 = '0; la4 = '0; lb4 = '0;
        @(negedge clk); st1 = 1'b1; st2 = 1'b1; st3 = 1'b1; st4 = 1'b1;
        for (int t = 0; t < 600; t++) begin
            a1 = rnd233(); b1 = rnd233();
            a2 = 8'($urandom); b2 = 8'($urandom);
            a3 = 9'($urandom); b3 = 9'($urandom);
            a4 = 8'($urandom); b4 = 8'($urandom);
            if (t % p1 == 0) begin la1 = a1; lb1 = b1; end
            if (t % p2 == 0) begin la2 = a2; lb2 = b2; end
            if (t % p3 == 0) begin la3 = a3; lb3 = b3; end
            if (t % p4 == 0) begin la4 = a4; lb4 = b4; end
            @(posedge clk); #1;
            ex = (t % p1 == p1 - 1);
            n_cmp++; if (dn1 !== ex) begin n_bad++; $display("FAIL b2b_done_w233 t=%0d got %b expected %b", t, dn1, ex); end
            if (ex) begin
                e = clmul(la1, lb1);
                n_cmp++; if (c1 !== e) begin n_bad++; $display("FAIL b2b_c_w233 t=%0d got %0h expected %0h", t, c1, e); end
            end
            ex = (t % p2 == p2 - 1);
            n_cmp++; if (dn2 !== ex) begin n_bad++; $display("FAIL b2b_done_w8d3 t=%0d got %b expected %b", t, dn2, ex); end
            if (ex) begin
                e = clmul({225'b0, la2}, {225'b0, lb2});
                n_cmp++; if (c2 !== e[15:0]) begin n_bad++; $display("FAIL b2b_c_w8d3 t=%0d got %0h expected %0h", t, c2, e[15:0]); end
            end
            ex = (t % p3 == p3 - 1);
            n_cmp++; if (dn3 !== ex) begin n_bad++; $display("FAIL b2b_done_w9d2 t=%0d got %b expected %b", t, dn3, ex); end
            if (ex) begin
                e = clmul({224'b0, la3}, {224'b0, lb3});
                n_cmp++; if (c3 !== e[17:0]) begin n_bad++; $display("FAIL b2b_c_w9d2 t=%0d got %0h expected %0h", t, c3, e[17:0]); end
            end
            ex = (t % p4 == p4 - 1);
            n_cmp++; if (dn4 !== ex) begin n_bad++; $display("FAIL b2b_done_w8d4 t=%0d got %b expected %b", t, dn4, ex); end
            if (ex) begin
                e = clmul({225'b0, la4}, {225'b0, lb4});
                n_cmp++; if (c4 !== e[15:0]) begin n_bad++; $display("FAIL b2b_c_w8d4 t=%0d got %0h expected %0h", t, c4, e[15:0]); end
            end
            @(negedge clk);
        end
        st1 = 1'b0; st2 = 1'b0; st3 = 1'b0; st4 = 1'b0;
        repeat (150) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_squares();
        test_digit3();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_karatsuba_gf2.md
SEQ_KARATSUBA_GF2 -- requirements
Module: seq_karatsuba_gf2

Interface
REQ-001 Parameter WIDTH, default 233, operand width in bits (SHALL be >= 4).
REQ-002 Parameter DIGIT, default 1, multiplier bits consumed per cycle by each sub-product (SHALL be 1..WIDTH/2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; operands are sampled when start=1 and the block is in IDLE.
REQ-006 a  input  WIDTH  operand A, a GF(2)[x] polynomial with bit i the coefficient of x^i.
REQ-007 b  input  WIDTH  operand B, same encoding.
REQ-008 busy  output  1  high in RUN and COMBINE.
REQ-009 done  output  1  one-cycle pulse when c is updated.
REQ-010 c  output  2*WIDTH  carry-less product A*B; bit 2*WIDTH-1 is always 0.

Function
REQ-011 Split: L = floor(WIDTH/2), H = WIDTH-L; Ah=a[WIDTH-1:L], Al=a[L-1:0], same for b; all WIDTH bits are used.
REQ-012 Three sub-products SHALL be computed concurrently, carry-less (XOR accumulate): Phh=Ah*Bh, Pll=Al*Bl, Pm=(Ah^Al)*(Bh^Bl), with Al/Bl zero-extended to H bits.
REQ-013 Combine: c = (Phh<<2L) ^ ((Pm^Phh^Pll)<<L) ^ Pll; no integer subtraction anywhere.
REQ-014 FSM states IDLE, RUN, COMBINE; IDLE->RUN on start; RUN->COMBINE after K=ceil(H/DIGIT) cycles; COMBINE->IDLE after one cycle.
REQ-015 On the accepting edge, a, b are latched into internal registers; later changes on a, b SHALL NOT affect the result.
REQ-016 In RUN, each sub-product processes DIGIT multiplier bits per cycle, LSB first; in the final cycle, bits beyond H are treated as 0.
REQ-017 A 1-bit cycle counter SHALL NOT be used; the counter width SHALL be clog2(K+1) and SHALL NOT wrap.
REQ-018 Latency: done=1 and the new c are visible exactly K+1 edges after the accepting edge; throughput is one product per K+2 cycles.
REQ-019 start while busy=1 SHALL be ignored; start is level-sampled only in IDLE, and start held high re-triggers immediately after return to IDLE.
REQ-020 c SHALL hold its value from one done pulse until the next done pulse or reset.
REQ-021 done SHALL be high for exactly one cycle per accepted request; busy SHALL be 0 in that cycle.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, busy=0, done=0, c=0, clear accumulators and counter, and abort any operation in progress without a done pulse.
REQ-023 start during the reset cycle SHALL be ignored; the first acceptable start is at the edge after rst deasserts.

Structure
REQ-024 Package karatsuba_pkg SHALL hold the state enum and a ceil-division/clog2 helper shared with other library multipliers.
REQ-025 One sub-module, clmul_digit_serial (parameters N, DIGIT; ports clk, rst, load, x, y, p), instantiated three times; FSM and combine logic live in the top module.

Verification
REQ-026 WIDTH=233, DIGIT=1, a=1, b=1, start pulse -> busy for 118 cycles, done at edge 118, c=1.
REQ-027 WIDTH=233, DIGIT=1, a=b=2^232 -> c=2^464; a=b=x^116+1 -> c=x^232+1 (cross-term cancels).
REQ-028 WIDTH=8, DIGIT=3, a=b=0xFF -> K=2, done 3 edges after start, c=0x5555.
REQ-029 Start accepted, rst asserted in RUN cycle 5, then new start with a=3, b=5 -> no done for the first request; second request c=0xF.
REQ-030 start held high with changing a, b for 600 cycles -> back-to-back products every K+2 cycles, each equal to a software clmul of operands latched at acceptance; random sweep over WIDTH in {8,9,233} and DIGIT in {1,2,4}.
